alu_issue_ctrl: RTL and testbench

//  Upstream issue stage for alu_4bit. Buffers {fnselec,a,b} commands in a FIFO,

---
 rtl/alu_issue_ctrl.sv | 125 ++++++++++++
 tb/tb_alu_issue_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// Issue stage in front of alu_4bit: command FIFO, registered op slot driving the ALU, and a
// registered valid/ready result slot. Optional sticky flags are enabled with ALU_STICKY_FLAGS_EN.
module alu_issue_ctrl #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_fn,
  input  logic [3:0] cmd_a,
  input  logic [3:0] cmd_b,
  output logic [2:0] alu_fnselec,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  input  logic [3:0] alu_res,
  input  logic       alu_zero,
  input  logic       alu_overflow,
  input  logic       alu_carry,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [3:0] res_data,
  output logic [2:0] res_fn,
  output logic [2:0] res_flags
`ifdef ALU_STICKY_FLAGS_EN
  ,
  input  logic       sticky_clr,
  output logic       sticky_ovf,
  output logic       sticky_carry
`endif
);

  // state | meaning
  // IDLE  | op slot empty, alu_* hold the last issued op
  // EXEC  | op slot full, result slot free or draining this cycle
  // STALL | op slot full, result slot blocked; alu_* held stable
  typedef enum logic [1:0] {IDLE, EXEC, STALL} state_t;

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  state_t        state;
  logic [10:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [10:0]   head;
  logic          empty;
  logic          full;
  logic          push;
  logic          pop;
  logic          op_full;
  logic          retire;

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign cmd_ready = !full;
  assign push      = cmd_valid && !full;
  assign op_full   = (state != IDLE);
  assign retire    = op_full && (!res_valid || res_ready);
  assign pop       = !empty && (!op_full || retire);
  assign head      = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= {cmd_fn, cmd_a, cmd_b};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      alu_fnselec <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      res_valid   <= 1'b0;
      res_data    <= '0;
      res_fn      <= '0;
      res_flags   <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr                      <= rd_ptr + PW'(1);
        {alu_fnselec, alu_a, alu_b} <= head;
      end
      if (retire) begin
        res_valid <= 1'b1;
        res_data  <= alu_res;
        res_fn    <= alu_fnselec;
        res_flags <= {alu_zero, alu_overflow, alu_carry};
      end else if (res_ready) begin
        res_valid <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (pop) state <= EXEC;
        end
        EXEC, STALL: begin
          if (retire) state <= pop ? EXEC : IDLE;
          else        state <= STALL;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ALU_STICKY_FLAGS_EN
  // A flag retiring in the same cycle as a clear wins over the clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_ovf   <= 1'b0;
      sticky_carry <= 1'b0;
    end else begin
      if (retire && alu_overflow) sticky_ovf <= 1'b1;
      else if (sticky_clr)        sticky_ovf <= 1'b0;
      if (retire && alu_carry)    sticky_carry <= 1'b1;
      else if (sticky_clr)        sticky_carry <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural 4-bit ALU closing the loop.
// Define ALU_STICKY_FLAGS_EN to also exercise the sticky flag ports.
module tb_alu_issue_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_fn;
  logic [3:0] cmd_a;
  logic [3:0] cmd_b;
  logic [2:0] alu_fnselec;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [3:0] alu_res;
  logic       alu_zero;
  logic       alu_overflow;
  logic       alu_carry;
  logic       res_valid;
  logic       res_ready;
  logic [3:0] res_data;
  logic [2:0] res_fn;
  logic [2:0] res_flags;
`ifdef ALU_STICKY_FLAGS_EN
  logic       sticky_clr;
  logic       sticky_ovf;
  logic       sticky_carry;
`endif

  int checks = 0;
  int errors = 0;

  alu_issue_ctrl #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_fn(cmd_fn), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .alu_fnselec(alu_fnselec), .alu_a(alu_a), .alu_b(alu_b),
    .alu_res(alu_res), .alu_zero(alu_zero),
    .alu_overflow(alu_overflow), .alu_carry(alu_carry),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_fn(res_fn), .res_flags(res_flags)
`ifdef ALU_STICKY_FLAGS_EN
    , .sticky_clr(sticky_clr), .sticky_ovf(sticky_ovf), .sticky_carry(sticky_carry)
`endif
  );

  always #5 clk = ~clk;

  // ALU: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 not a, 110 lt, 111 eq
  logic [4:0] sum;
  always_comb begin
    sum          = 5'd0;
    alu_res      = 4'd0;
    alu_overflow = 1'b0;
    alu_carry    = 1'b0;
    case (alu_fnselec)
      3'd0: begin
        sum          = {1'b0, alu_a} + {1'b0, alu_b};
        alu_res      = sum[3:0];
        alu_carry    = sum[4];
        alu_overflow = (alu_a[3] == alu_b[3]) && (sum[3] != alu_a[3]);
      end
      3'd1: begin
        sum          = {1'b0, alu_a} + {1'b0, ~alu_b} + 5'd1;
        alu_res      = sum[3:0];
        alu_carry    = sum[4];
        alu_overflow = (alu_a[3] != alu_b[3]) && (sum[3] != alu_a[3]);
      end
      3'd2: alu_res = alu_a & alu_b;
      3'd3: alu_res = alu_a | alu_b;
      3'd4: alu_res = alu_a ^ alu_b;
      3'd5: alu_res = ~alu_a;
      3'd6: alu_res = {3'b000, alu_a < alu_b};
      default: alu_res = {3'b000, alu_a == alu_b};
    endcase
    alu_zero = (alu_res == 4'd0);
  end

  typedef struct {
    logic [2:0] fn;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] res;
    logic [2:0] flags;
  } vec_t;

  vec_t vecs [11];
  logic [3:0] seq_res [5];
  logic [2:0] seq_fn  [5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic drive_cmd(input logic [2:0] fn, input logic [3:0] a, input logic [3:0] b);
    cmd_valid = 1'b1;
    cmd_fn    = fn;
    cmd_a     = a;
    cmd_b     = b;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_res_valid"}, res_valid, 0);
    check({tag, "_cmd_ready"}, cmd_ready, 1);
    check({tag, "_alu_ops"}, {alu_fnselec, alu_a, alu_b}, 0);
    check({tag, "_res_slot"}, {res_data, res_fn, res_flags}, 0);
  endtask

  initial begin
    int lat;
    int acc;
    int got;
    int first_t;
    int last_t;
    logic took;

    vecs[0]  = '{3'd0, 4'h7, 4'h1, 4'h8, 3'b010};
    vecs[1]  = '{3'd1, 4'h3, 4'h3, 4'h0, 3'b101};
    vecs[2]  = '{3'd7, 4'h5, 4'h5, 4'h1, 3'b000};
    vecs[3]  = '{3'd2, 4'hC, 4'hA, 4'h8, 3'b000};
    vecs[4]  = '{3'd3, 4'hC, 4'hA, 4'hE, 3'b000};
    vecs[5]  = '{3'd4, 4'hC, 4'hC, 4'h0, 3'b100};
    vecs[6]  = '{3'd5, 4'h5, 4'h0, 4'hA, 3'b000};
    vecs[7]  = '{3'd6, 4'h2, 4'h5, 4'h1, 3'b000};
    vecs[8]  = '{3'd0, 4'h9, 4'h8, 4'h1, 3'b011};
    vecs[9]  = '{3'd1, 4'h2, 4'h5, 4'hD, 3'b000};
    vecs[10] = '{3'd0, 4'hF, 4'h1, 4'h0, 3'b101};

    seq_fn[0] = 3'd2; seq_res[0] = 4'h8;
    seq_fn[1] = 3'd3; seq_res[1] = 4'hE;
    seq_fn[2] = 3'd4; seq_res[2] = 4'h5;
    seq_fn[3] = 3'd5; seq_res[3] = 4'hC;
    seq_fn[4] = 3'd6; seq_res[4] = 4'h0;

    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_fn    = 3'd0;
    cmd_a     = 4'd0;
    cmd_b     = 4'd0;
    res_ready = 1'b1;
`ifdef ALU_STICKY_FLAGS_EN
    sticky_clr = 1'b0;
`endif
    tick();
    tick();
    check_all_zero("reset");
`ifdef ALU_STICKY_FLAGS_EN
    check("reset_sticky", {sticky_ovf, sticky_carry}, 0);
`endif
    rst = 1'b0;
    tick();

    // single ops through an empty pipe
    for (int i = 0; i < 11; i++) begin
      drive_cmd(vecs[i].fn, vecs[i].a, vecs[i].b);
      tick();
      cmd_valid = 1'b0;
      lat = 0;
      while (!res_valid && lat < 10) begin
        tick();
        lat++;
      end
      check($sformatf("vec%0d_latency", i), lat, 2);
      check($sformatf("vec%0d_data", i), res_data, vecs[i].res);
      check($sformatf("vec%0d_fn", i), res_fn, vecs[i].fn);
      check($sformatf("vec%0d_flags", i), res_flags, vecs[i].flags);
      tick();
      check($sformatf("vec%0d_drained", i), res_valid, 0);
    end

    // back-to-back issue, one result per cycle in order
    got = 0;
    first_t = -1;
    last_t = -1;
    for (int t = 0; t < 12; t++) begin
      if (res_valid) begin
        if (got < 5) begin
          check($sformatf("b2b%0d_data", got), res_data, seq_res[got]);
          check($sformatf("b2b%0d_fn", got), res_fn, seq_fn[got]);
        end
        if (first_t < 0) first_t = t;
        last_t = t;
        got++;
      end
      if (t < 5) drive_cmd(seq_fn[t], (t == 2) ? 4'h6 : (t == 3) ? 4'h3 : (t == 4) ? 4'h9 : 4'hC,
                           (t == 2) ? 4'h3 : (t == 4) ? 4'h2 : 4'hA);
      else cmd_valid = 1'b0;
      tick();
    end
    check("b2b_count", got, 5);
    check("b2b_span", last_t - first_t, 4);

    // fill with res_ready low: FIFO + op slot + result slot
    res_ready = 1'b0;
    acc = 0;
    for (int it = 0; it < 10; it++) begin
      drive_cmd(3'd0, acc[3:0], 4'd0);
      took = cmd_ready;
      tick();
      if (took) acc++;
    end
    check("fill_accepted", acc, 6);
    check("fill_cmd_ready", cmd_ready, 0);
    check("fill_res_head", {res_valid, res_data}, {1'b1, 4'h0});
    for (int it = 0; it < 3; it++) begin
      check($sformatf("stall%0d_alu", it), {alu_fnselec, alu_a, alu_b}, {3'd0, 4'h1, 4'h0});
      check($sformatf("stall%0d_res", it), {res_valid, res_data}, {1'b1, 4'h0});
      tick();
    end
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      check($sformatf("drain%0d", i), {res_valid, res_data}, {1'b1, 4'(i)});
      tick();
    end
    check("drain_empty", res_valid, 0);

    // reset with ops in flight
    res_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_cmd(3'd3, 4'(i + 1), 4'h8);
      tick();
    end
    cmd_valid = 1'b0;
    rst = 1'b1;
    tick();
    check_all_zero("midrst");
    rst = 1'b0;
    res_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    check("midrst_no_ghost", {res_valid, cmd_ready}, 2'b01);

`ifdef ALU_STICKY_FLAGS_EN
    drive_cmd(3'd0, 4'h7, 4'h1);
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    tick();
    check("sticky_set", sticky_ovf, 1);
    sticky_clr = 1'b1;
    tick();
    sticky_clr = 1'b0;
    check("sticky_clr_first", {sticky_ovf, sticky_carry}, 0);
    drive_cmd(3'd0, 4'h7, 4'h1);
    tick();
    cmd_valid = 1'b0;
    tick();
    sticky_clr = 1'b1;
    tick();
    sticky_clr = 1'b0;
    check("sticky_set_wins", sticky_ovf, 1);
    tick();
    sticky_clr = 1'b1;
    tick();
    sticky_clr = 1'b0;
    check("sticky_clr_alone", {sticky_ovf, sticky_carry}, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
